// File: rtl/tlb_array.sv
// tlb_array: joint TLB storage with two combinational search ports, TLBWI/TLBWR/TLBP/TLBR,
// the CP0 Random counter and the TLB-buffer flush pulse.
module tlb_array #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       cp0_asid,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    input  logic [18:0]      s0_vpn2,
    output logic             s0_found,
    output logic [77:0]      s0_entry,
    input  logic [18:0]      s1_vpn2,
    output logic             s1_found,
    output logic [77:0]      s1_entry,
    input  logic             w_req,
    input  logic             w_random,
    input  logic [IDX_W-1:0] w_index,
    input  logic [77:0]      w_entry,
    input  logic             p_req,
    input  logic [18:0]      p_vpn2,
    output logic             p_done,
    output logic             p_found,
    output logic [IDX_W-1:0] p_index,
    input  logic             r_req,
    input  logic [IDX_W-1:0] r_index,
    output logic             r_done,
    output logic [77:0]      r_entry,
    output logic [IDX_W-1:0] random,
    output logic             tlb_buffer_flush
);
    // Entry layout: vpn2[77:59] asid[58:51] g[50] pfn0[49:30] c0[29:27] d0[26] v0[25]
    //               pfn1[24:5] c1[4:2] d1[1] v1[0]
    localparam logic [IDX_W-1:0] MAX = IDX_W'(NUM_ENTRIES - 1);

    logic [77:0]      mem [NUM_ENTRIES];
    logic [7:0]       asid_q;
    logic [IDX_W:0]   s0_hit, s1_hit, p_hit;

    // Returns {found, index}; scanning downwards leaves the lowest matching index.
    function automatic logic [IDX_W:0] lookup(input logic [18:0] vpn);
        lookup = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (mem[i][77:59] == vpn && (mem[i][50] || mem[i][58:51] == cp0_asid))
                lookup = {1'b1, IDX_W'(i)};
    endfunction

    always_comb begin
        s0_hit = lookup(s0_vpn2);
        s1_hit = lookup(s1_vpn2);
        p_hit = lookup(p_vpn2);
        s0_found = s0_hit[IDX_W];
        s1_found = s1_hit[IDX_W];
        s0_entry = s0_found ? mem[s0_hit[IDX_W-1:0]] : '0;
        s1_entry = s1_found ? mem[s1_hit[IDX_W-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
            p_done <= 1'b0;
            p_found <= 1'b0;
            p_index <= '0;
            r_done <= 1'b0;
            r_entry <= '0;
            random <= MAX;
            asid_q <= cp0_asid;
            tlb_buffer_flush <= 1'b0;
        end else begin
            if (w_req) mem[w_random ? random : w_index] <= w_entry;
            p_done <= p_req;
            if (p_req) {p_found, p_index} <= p_hit;
            r_done <= r_req;
            if (r_req) r_entry <= mem[r_index];
            random <= (cp0_wired_we || cp0_wired >= MAX || random == cp0_wired) ? MAX : random - 1'b1;
            asid_q <= cp0_asid;
            tlb_buffer_flush <= w_req || cp0_asid != asid_q;
        end
    end
endmodule
